// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot controller: state
// encoding, address/count widths, the stalled-fetch instruction and lane order.
package imem_boot_ctrl_pkg;

  localparam int ADR_W = 32;
  localparam int CNT_W = 17;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Lane i of a memory word holds the byte at address a+i.
  localparam bit LANE_LITTLE_ENDIAN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PAD  = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Reorders a fetched word into the lane order the core decodes.
  function automatic logic [31:0] order_lanes(input logic [31:0] rdata);
    return LANE_LITTLE_ENDIAN ? rdata
                              : {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
  endfunction

endpackage

// File: rtl/imem_port_mux.sv
// Selects who owns the single memory port: the loader (stream bytes and pad
// bytes at ptr) or the CPU fetch path (cpu_pc) once the image is running.
module imem_port_mux
  import imem_boot_ctrl_pkg::*;
(
  input  state_t           state,
  input  logic [ADR_W-1:0] ptr,
  input  logic [31:0]      cpu_pc,
  input  logic             hs,
  input  logic             overflow,
  input  logic             start,
  input  logic [7:0]       ld_data,
  output logic [ADR_W-1:0] mem_adr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    mem_adr   = ptr;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (state)
      ST_LOAD: begin
        mem_we    = hs && !overflow;
        mem_wdata = ld_data;
      end
      // A restart in the same cycle abandons the pad byte along with the image.
      ST_PAD:  mem_we  = !start;
      ST_RUN:  mem_adr = cpu_pc;
      default: ;
    endcase
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller for the MIPS instruction memory: streams an image in over a
// valid/ready byte handshake, pads it to a word boundary, then hands fetch to the CPU.
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int unsigned      MEM_BYTES = 65536,
  parameter logic [ADR_W-1:0] BASE_ADR  = '0,
  parameter logic [31:0]      NOP_WORD  = NOP_WORD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic [31:0]      cpu_pc,
  output logic [31:0]      cpu_instr,
  output logic             cpu_stall,
  output logic [ADR_W-1:0] mem_adr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam logic [ADR_W-1:0] ADR_MASK = ADR_W'(MEM_BYTES - 1);
  localparam logic [ADR_W-1:0] BASE_PTR = BASE_ADR & ADR_MASK;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_BYTES);

  state_t           state, state_nxt;
  logic [ADR_W-1:0] ptr, ptr_nxt, ptr_inc;
  logic [CNT_W-1:0] byte_cnt_nxt;
  logic             err_nxt;
  logic             hs;
  logic             overflow;

  // The pointer wraps at the memory size, so it always equals BASE+byte_cnt mod MEM_BYTES.
  assign ptr_inc  = (ptr + ADR_W'(1)) & ADR_MASK;
  assign ld_ready = (state == ST_LOAD) && !start;
  assign hs       = ld_valid && ld_ready;
  assign overflow = hs && (byte_cnt == CNT_FULL);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    byte_cnt_nxt = byte_cnt;
    err_nxt      = err;
    if (start) begin
      state_nxt    = ST_LOAD;
      ptr_nxt      = BASE_PTR;
      byte_cnt_nxt = '0;
      err_nxt      = 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (overflow) begin
            err_nxt   = 1'b1;
            state_nxt = ST_ERR;
          end else if (hs) begin
            ptr_nxt      = ptr_inc;
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
            if (ld_last) state_nxt = (ptr_inc[1:0] == 2'b00) ? ST_RUN : ST_PAD;
          end
        end
        ST_PAD: begin
          ptr_nxt      = ptr_inc;
          byte_cnt_nxt = byte_cnt + CNT_W'(1);
          if (ptr_inc[1:0] == 2'b00) state_nxt = ST_RUN;
        end
        // The misaligned fetch still goes through; it is only flagged.
        ST_RUN:  if (cpu_pc[1:0] != 2'b00) err_nxt = 1'b1;
        ST_IDLE, ST_ERR: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= BASE_PTR;
      byte_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      byte_cnt <= byte_cnt_nxt;
      err      <= err_nxt;
    end
  end

  assign done      = (state == ST_RUN);
  assign cpu_stall = !done;
  assign cpu_instr = done ? order_lanes(mem_rdata) : NOP_WORD;

  imem_port_mux u_port_mux (
    .state     (state),
    .ptr       (ptr),
    .cpu_pc    (cpu_pc),
    .hs        (hs),
    .overflow  (overflow),
    .start     (start),
    .ld_data   (ld_data),
    .mem_adr   (mem_adr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: directed scenarios plus randomized loads, checked every
// cycle against a count-based reference model and a byte-array image of the memory.
module tb_imem_boot_ctrl;

  localparam int          MEM  = 16;
  localparam int          BASE = 0;
  localparam logic [31:0] NOP  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [31:0] cpu_pc = 32'h0;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic [31:0] mem_adr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;
  logic [16:0] byte_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // phys: the memory the DUT actually writes. m_img: what the image must be.
  logic [7:0] phys  [MEM];
  logic [7:0] m_img [MEM];

  // Reference model: loading / padding / running flags and a byte count.
  bit m_stream, m_run, m_err;
  int m_pad, m_cnt;

  always #5 clk = ~clk;

  imem_boot_ctrl #(
    .MEM_BYTES (MEM),
    .BASE_ADR  (32'(BASE)),
    .NOP_WORD  (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_pc    (cpu_pc),
    .cpu_instr (cpu_instr),
    .cpu_stall (cpu_stall),
    .mem_adr   (mem_adr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .err       (err),
    .byte_cnt  (byte_cnt)
  );

  always_comb
    mem_rdata = {phys[mem_adr[3:0] + 4'd3], phys[mem_adr[3:0] + 4'd2],
                 phys[mem_adr[3:0] + 4'd1], phys[mem_adr[3:0]]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] img_word(input logic [31:0] a);
    int b;
    b = int'(a % 32'(MEM));
    return {m_img[(b + 3) % MEM], m_img[(b + 2) % MEM], m_img[(b + 1) % MEM], m_img[b]};
  endfunction

  // Compare outputs against the model mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin : model
    logic [31:0] e_adr;
    logic        e_ready, e_we;
    int          a;
    if (!rst_n) begin
      m_stream = 0; m_pad = 0; m_run = 0; m_err = 0; m_cnt = 0;
    end
    a       = (BASE + m_cnt) % MEM;
    e_ready = m_stream && !start;
    e_we    = (e_ready && ld_valid && m_cnt < MEM) || (m_pad > 0 && !start);
    e_adr   = m_run ? cpu_pc : 32'(a);
    check("ld_ready",  32'(ld_ready),  32'(e_ready));
    check("mem_we",    32'(mem_we),    32'(e_we));
    check("mem_adr",   mem_adr,        e_adr);
    if (e_we) check("mem_wdata", 32'(mem_wdata), (m_pad > 0) ? 32'h0 : 32'(ld_data));
    check("cpu_stall", 32'(cpu_stall), 32'(!m_run));
    check("done",      32'(done),      32'(m_run));
    check("err",       32'(err),       32'(m_err));
    check("byte_cnt",  32'(byte_cnt),  32'(m_cnt));
    check("cpu_instr", cpu_instr,      m_run ? img_word(cpu_pc) : NOP);
    if (mem_we) phys[mem_adr[3:0]] = mem_wdata;
    if (rst_n) begin
      if (start) begin
        m_stream = 1; m_pad = 0; m_run = 0; m_err = 0; m_cnt = 0;
      end else if (m_stream && ld_valid) begin
        if (m_cnt == MEM) begin
          m_err = 1; m_stream = 0;
        end else begin
          m_img[a] = ld_data;
          m_cnt++;
          if (ld_last) begin
            m_stream = 0;
            m_pad    = (4 - ((BASE + m_cnt) % 4)) % 4;
            m_run    = (m_pad == 0);
          end
        end
      end else if (m_pad > 0) begin
        m_img[a] = 8'h00;
        m_cnt++;
        m_pad--;
        m_run = (m_pad == 0);
      end else if (m_run && cpu_pc[1:0] != 2'b00) begin
        m_err = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Idle cycles carry a random ld_last that must be ignored without ld_valid.
  task automatic idle(input int n);
    repeat (n) begin
      ld_last = 1'($urandom);
      tick();
    end
    ld_last = 1'b0;
  endtask

  task automatic count_pads(output int pads);
    pads = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (done) break;
      if (mem_we && mem_wdata == 8'h00) pads++;
      tick();
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int pads;
    int len;
    for (int i = 0; i < MEM; i++) begin
      phys[i] = 8'h00;
      m_img[i] = 8'h00;
    end

    tick(); #1;
    check("reset stall",  32'(cpu_stall), 32'h1);
    check("reset ready",  32'(ld_ready),  32'h0);
    check("reset we",     32'(mem_we),    32'h0);
    check("reset cnt",    32'(byte_cnt),  32'h0);
    check("reset done",   32'(done),      32'h0);
    check("reset instr",  cpu_instr,      NOP);
    tick();
    rst_n = 1'b1;
    idle(1);

    // Aligned 8-byte image: no pad cycles.
    pulse_start();
    for (int b = 1; b <= 8; b++) send_byte(8'(b), b == 8);
    count_pads(pads);
    check("load8 pads",  32'(pads),      32'h0);
    check("load8 done",  32'(done),      32'h1);
    check("load8 cnt",   32'(byte_cnt),  32'h8);
    check("load8 stall", 32'(cpu_stall), 32'h0);
    cpu_pc = 32'h0; #1;
    check("load8 word0", cpu_instr, 32'h0403_0201);
    cpu_pc = 32'h4; #1;
    check("load8 word4", cpu_instr, 32'h0807_0605);

    // 5-byte image: three pad bytes complete word 4.
    pulse_start();
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0); send_byte(8'hEE, 1'b1);
    count_pads(pads);
    check("load5 pads", 32'(pads),     32'h3);
    check("load5 cnt",  32'(byte_cnt), 32'h8);
    check("load5 done", 32'(done),     32'h1);
    cpu_pc = 32'h4; #1;
    check("load5 word4", cpu_instr, 32'h0000_00EE);
    check("load5 stall", 32'(cpu_stall), 32'h0);
    cpu_pc = 32'h0; #1;
    check("load5 word0", cpu_instr, 32'hDDCC_BBAA);

    // Misaligned fetch flags err but keeps running.
    tick();
    cpu_pc = 32'h6;
    tick(); #1;
    check("misalign err",  32'(err),  32'h1);
    check("misalign done", 32'(done), 32'h1);
    cpu_pc = 32'h0;

    // Restart from RUN.
    pulse_start(); #1;
    check("restart stall", 32'(cpu_stall), 32'h1);
    check("restart instr", cpu_instr,      NOP);
    check("restart ready", 32'(ld_ready),  32'h1);
    check("restart cnt",   32'(byte_cnt),  32'h0);
    check("restart err",   32'(err),       32'h0);

    // Reset in the middle of a load.
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    idle(1);
    rst_n = 1'b0; #1;
    check("midrst stall", 32'(cpu_stall), 32'h1);
    check("midrst ready", 32'(ld_ready),  32'h0);
    check("midrst cnt",   32'(byte_cnt),  32'h0);
    check("midrst we",    32'(mem_we),    32'h0);
    tick();
    rst_n = 1'b1;

    // start together with a byte in IDLE: the byte is not taken.
    start = 1'b1; ld_valid = 1'b1; ld_data = 8'h99; #1;
    check("idle start ready", 32'(ld_ready), 32'h0);
    check("idle start we",    32'(mem_we),   32'h0);
    tick();
    start = 1'b0; ld_valid = 1'b0;

    // Overflow: the 17th byte into a 16-byte memory.
    pulse_start();
    for (int k = 0; k < MEM; k++) send_byte(8'(8'h40 + k), 1'b0);
    ld_valid = 1'b1; ld_data = 8'h77; #1;
    check("ovf we",    32'(mem_we),   32'h0);
    check("ovf ready", 32'(ld_ready), 32'h1);
    check("ovf cnt",   32'(byte_cnt), 32'(MEM));
    tick();
    ld_valid = 1'b0; #1;
    check("ovf err",   32'(err),       32'h1);
    check("ovf done",  32'(done),      32'h0);
    check("ovf ready2", 32'(ld_ready), 32'h0);
    check("ovf stall", 32'(cpu_stall), 32'h1);
    pulse_start(); #1;
    check("ovf restart err",   32'(err),      32'h0);
    check("ovf restart ready", 32'(ld_ready), 32'h1);

    // Randomized loads, restarts, resets and fetches.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      pulse_start();
      len = int'($urandom_range(1, 18));
      for (int k = 0; k < len; k++) begin
        idle(int'($urandom_range(0, 2)));
        if ($urandom_range(0, 24) == 0) start = 1'b1;
        send_byte(8'($urandom), k == len - 1);
        start = 1'b0;
      end
      repeat (8) begin
        cpu_pc = ($urandom_range(0, 5) == 0) ? 32'($urandom)
                                            : 32'($urandom_range(0, 3) * 4);
        tick();
      end
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Sequences the byte-addressed, little-endian instruction memory of the single-cycle MIPS core.
- Loads a program into the memory from a byte stream using a valid/ready handshake.
- Pads the image to a word boundary and stalls the CPU until the image is complete.
- After loading, muxes the memory port to the CPU program counter for fetch; a new load can be started later.

Parameters:
MEM_BYTES, 65536, instruction memory size in bytes (power of two); load addresses wrap at this size.
BASE_ADR, 0, byte address of the first loaded byte.
NOP_WORD, 32'h0000_0000, instruction returned to the CPU while it is stalled.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a (re)load
ld_valid  in  1  stream byte valid
ld_data  in  8  stream byte
ld_last  in  1  marks the final byte of the image (qualified by ld_valid)
ld_ready  out  1  controller accepts a byte this cycle
cpu_pc  in  32  CPU fetch address
cpu_instr  out  32  instruction to the CPU
cpu_stall  out  1  holds the CPU PC and register writes
mem_adr  out  32  memory address (read and write share one port)
mem_we  out  1  byte write enable
mem_wdata  out  8  byte to write
mem_rdata  in  32  {mem[a+3],mem[a+2],mem[a+1],mem[a]}, combinational
done  out  1  image loaded, CPU running
err  out  1  sticky: overflow or misaligned fetch
byte_cnt  out  17  bytes written in the current load, including pad bytes

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=BASE_ADR, byte_cnt=0, err=0, done=0.
  - Reset outputs: cpu_stall=1, ld_ready=0, mem_we=0.
- States and transitions:
  - IDLE: start -> LOAD.
  - LOAD: ld_ready=1. A handshake (ld_valid&ld_ready) causes:
    - mem_we=1, mem_adr=ptr, mem_wdata=ld_data, combinationally in the same cycle;
    - on the next edge, ptr+=1 and byte_cnt+=1.
    - Handshake with ld_last: if the new ptr[1:0]==0 -> RUN, else -> PAD.
  - PAD: ld_ready=0, mem_we=1, mem_wdata=8'h00, mem_adr=ptr, ptr+=1 each cycle. Leave to RUN on the edge where the new ptr[1:0]==0. Maximum 3 cycles.
  - RUN: cpu_stall=0, done=1, mem_adr=cpu_pc, cpu_instr=mem_rdata (zero latency). start -> LOAD: ptr=BASE_ADR, byte_cnt=0, done=0.
  - ERR: entered on overflow. cpu_stall=1, ld_ready=0, done=0. Only start or reset leaves it; start -> LOAD.
- Overflow: a handshake when byte_cnt==MEM_BYTES is not written (mem_we=0), sets err=1 and goes to ERR. Address = (BASE_ADR+byte_cnt) mod MEM_BYTES.
- Misaligned fetch: in RUN, cpu_pc[1:0]!=0 sets err=1 at the next edge. The fetch still passes through and the state stays RUN.
- err is cleared only by start or reset.
- Outside RUN: cpu_instr=NOP_WORD, cpu_stall=1, and mem_adr is driven by the controller.
- start during LOAD or PAD restarts: ptr=BASE_ADR, byte_cnt=0, any byte in the same cycle is dropped (ld_ready=0 that cycle).
- start and ld_valid in the same cycle in IDLE: the byte is not accepted (ld_ready=0 in IDLE).
- ld_last without ld_valid is ignored.
- Reset mid-load: the memory contents are left as they are, and the controller returns to IDLE and stalls the CPU.
- A zero-length image is impossible; a load ends only with a handshake carrying ld_last.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=0, LOAD=1, PAD=2, RUN=3, ERR=4 (3 bits);
  - the NOP_WORD constant;
  - the byte-lane order (little-endian) constant.
- One natural sub-module, imem_port_mux: combinational selection of mem_adr, mem_we and mem_wdata, driven by state and ptr versus cpu_pc.
- The FSM, ptr and byte_cnt stay in imem_boot_ctrl.

Test Plan:
- Reset, start, stream the 8 bytes 01..08 with ld_last on 08 -> memory words at 0 and 4 = 32'h04030201 and 32'h08070605; RUN follows the edge after byte 08; byte_cnt=8; done=1; no PAD cycles.
- Stream 5 bytes AA..EE with ld_last on EE -> PAD writes 00 to addresses 5, 6, 7 over 3 cycles; word 4 = 32'h000000EE; byte_cnt=8; then RUN.
- In RUN, cpu_pc=4 -> cpu_instr=word 4 in the same cycle with cpu_stall=0; cpu_pc=6 -> err=1 next edge, state stays RUN.
- During LOAD with ld_valid held low, hold rst_n=0 for 1 cycle mid-stream -> immediately cpu_stall=1, ld_ready=0, byte_cnt=0, state IDLE; no write during reset.
- MEM_BYTES=16: stream 17 bytes without ld_last -> the 17th byte gives mem_we=0, err=1, state ERR; start -> LOAD with err=0.
- In RUN, pulse start -> next cycle cpu_stall=1, cpu_instr=NOP_WORD, ld_ready=1, byte_cnt=0.
